// File: rtl/nx_control_arbiter_pkg.sv
// Shared types for the Nexus control path: command/response formats, arbiter
// FSM states and the helper that classifies which commands produce a response.
package nx_control_arbiter_pkg;

    // Control command opcodes; encodings above CONTROL_RESET are unknown.
    typedef enum logic [3:0] {
        CONTROL_ID       = 4'd0,
        CONTROL_VERSION  = 4'd1,
        CONTROL_PARAM    = 4'd2,
        CONTROL_ACTIVE   = 4'd3,
        CONTROL_STATUS   = 4'd4,
        CONTROL_CYCLES   = 4'd5,
        CONTROL_INTERVAL = 4'd6,
        CONTROL_RESET    = 4'd7
    } control_command_t;

    // Parameter selectors carried in the payload of a PARAM command.
    typedef enum logic [3:0] {
        CONTROL_PARAM_COUNTER_WIDTH  = 4'd0,
        CONTROL_PARAM_ROWS           = 4'd1,
        CONTROL_PARAM_COLUMNS        = 4'd2,
        CONTROL_PARAM_NODE_INPUTS    = 4'd3,
        CONTROL_PARAM_NODE_OUTPUTS   = 4'd4,
        CONTROL_PARAM_NODE_REGISTERS = 4'd5
    } control_param_t;

    localparam int unsigned CONTROL_PAYLOAD_WIDTH = 28;

    typedef struct packed {
        control_command_t                   command;
        logic [CONTROL_PAYLOAD_WIDTH-1:0]   payload;
    } control_message_t;

    typedef logic [31:0] control_response_t;

    // Device identifier returned (low 24 bits) by the ID command.
    localparam logic [31:0] HW_DEV_ID = 32'h4E58_5301;

    typedef enum logic [1:0] {
        StIdle,
        StForward,
        StWait,
        StReturn
    } arb_state_e;

    // True for commands whose execution produces a response word.
    function automatic logic control_command_expects_response(input control_command_t cmd);
        case (cmd)
            CONTROL_ID,
            CONTROL_VERSION,
            CONTROL_PARAM,
            CONTROL_STATUS,
            CONTROL_CYCLES: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Parameterised round-robin arbiter. The search starts one past the last
// accepted grant and wraps; the pointer only moves when a grant is taken.
module nx_rr_arbiter #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic            en_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o
);

    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] cand;
    logic [31:0]     sum;
    logic            found;

    // Rotating priority search from last_q+1, modulo N.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        sum       = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            sum = 32'(last_q) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = IdxW'(sum);
            if (en_i && !found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

    // Remember the winner; reset value makes requester 0 win first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= IdxW'(N - 1);
        end else if (found) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/nx_control_arbiter.sv
// Shares the controller's single command/response stream between several
// command sources. One command is in flight at a time; if it expects a
// response the grant is held until that response reaches its owner, or until
// the watchdog gives up on the controller.
module nx_control_arbiter
    import nx_control_arbiter_pkg::*;
#(
    parameter int unsigned REQUESTERS = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  control_message_t [REQUESTERS-1:0] i_req_data,
    input  logic [REQUESTERS-1:0]             i_req_valid,
    output logic [REQUESTERS-1:0]             o_req_ready,
    output control_message_t                  o_ctrl_data,
    output logic                              o_ctrl_valid,
    input  logic                              i_ctrl_ready,
    input  control_response_t                 i_resp_data,
    input  logic                              i_resp_valid,
    output logic                              o_resp_ready,
    output control_response_t                 o_rsp_data,
    output logic [REQUESTERS-1:0]             o_rsp_valid,
    input  logic [REQUESTERS-1:0]             i_rsp_ready,
    output logic                              o_timeout
);

    localparam int unsigned IdxW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int unsigned WdW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e            state_q;
    control_message_t      cmd_q;
    logic                  ctrl_valid_q;
    control_response_t     rsp_q;
    logic [REQUESTERS-1:0] rsp_valid_q;
    logic [IdxW-1:0]       owner_q;
    logic [WdW-1:0]        wdog_q;
    logic                  timeout_q;

    logic                  arb_en;
    logic [REQUESTERS-1:0] arb_gnt;
    logic [IdxW-1:0]       arb_idx;
    logic [REQUESTERS-1:0] owner_onehot;
    logic                  wdog_expire;

    // Grants are only offered while no transaction is held.
    assign arb_en = (state_q == StIdle);

    nx_rr_arbiter #(
        .N    (REQUESTERS),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .clk_i     (i_clk),
        .rst_ni    (i_rst),
        .req_i     (i_req_valid),
        .en_i      (arb_en),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    // Owner decode for response steering and watchdog expiry detection.
    always_comb begin
        owner_onehot          = '0;
        owner_onehot[owner_q] = 1'b1;
        wdog_expire           = (TIMEOUT != 0) && ((32'(wdog_q) + 32'd1) == TIMEOUT);
    end

    assign o_req_ready  = arb_gnt;
    // Idle also drains stray responses, e.g. a late answer after a timeout.
    assign o_resp_ready = (state_q == StIdle) || (state_q == StWait);
    assign o_ctrl_data  = cmd_q;
    assign o_ctrl_valid = ctrl_valid_q;
    assign o_rsp_data   = rsp_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_timeout    = timeout_q;

    // Transaction FSM with registered command, response and timeout outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= StIdle;
            cmd_q        <= '0;
            ctrl_valid_q <= 1'b0;
            rsp_q        <= '0;
            rsp_valid_q  <= '0;
            owner_q      <= '0;
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|i_req_valid) begin
                        cmd_q        <= i_req_data[arb_idx];
                        owner_q      <= arb_idx;
                        ctrl_valid_q <= 1'b1;
                        state_q      <= StForward;
                    end
                end
                StForward: begin
                    if (i_ctrl_ready) begin
                        ctrl_valid_q <= 1'b0;
                        if (control_command_expects_response(cmd_q.command)) begin
                            wdog_q  <= '0;
                            state_q <= StWait;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StWait: begin
                    // A response in the expiry cycle takes precedence.
                    if (i_resp_valid) begin
                        rsp_q       <= i_resp_data;
                        rsp_valid_q <= owner_onehot;
                        state_q     <= StReturn;
                    end else if (wdog_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else if (TIMEOUT != 0) begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                StReturn: begin
                    if (i_rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nx_control_arbiter.sv
// Directed bench for nx_control_arbiter with two requesters and TIMEOUT=8.
module tb_nx_control_arbiter;
    import nx_control_arbiter_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    control_message_t [1:0]  req_data;
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    control_message_t        ctrl_data;
    logic                    ctrl_valid;
    logic                    ctrl_ready;
    control_response_t       resp_data;
    logic                    resp_valid;
    logic                    resp_ready;
    control_response_t       rsp_data;
    logic [1:0]              rsp_valid;
    logic [1:0]              rsp_ready;
    logic                    timeout;

    int                      total  = 0;
    int                      passed = 0;
    int                      failed = 0;
    logic [31:0]             id_word;
    logic [31:0]             id_resp;
    logic [1:0]              exp_gnt;

    always #5 clk = ~clk;

    nx_control_arbiter #(
        .REQUESTERS (2),
        .TIMEOUT    (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_data   (req_data),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .o_ctrl_data  (ctrl_data),
        .o_ctrl_valid (ctrl_valid),
        .i_ctrl_ready (ctrl_ready),
        .i_resp_data  (resp_data),
        .i_resp_valid (resp_valid),
        .o_resp_ready (resp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_timeout    (timeout)
    );

    function automatic control_message_t mk(input control_command_t c, input logic [27:0] p);
        control_message_t m;
        m.command = c;
        m.payload = p;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 2'b00;
        req_data   = '0;
        ctrl_ready = 1'b0;
        resp_data  = '0;
        resp_valid = 1'b0;
        rsp_ready  = 2'b00;
        id_word    = HW_DEV_ID;
        id_resp    = {8'd0, id_word[23:0]};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_ctrl_valid", ctrl_valid, 1'b0);
        check("rst_ctrl_data", ctrl_data, 32'd0);
        check("rst_resp_ready", resp_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_timeout", timeout, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Arbitration order: both requesters issue ID continuously
        req_valid   = 2'b11;
        req_data[0] = mk(CONTROL_ID, 28'd0);
        req_data[1] = mk(CONTROL_ID, 28'd0);
        for (int k = 0; k < 4; k++) begin
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check("arb_grant", req_ready, exp_gnt);
            tick();
            ctrl_ready = 1'b1;
            #1;
            check("arb_ctrl_valid", ctrl_valid, 1'b1);
            check("arb_ctrl_data", ctrl_data, mk(CONTROL_ID, 28'd0));
            tick();
            ctrl_ready = 1'b0;
            resp_valid = 1'b1;
            resp_data  = id_resp;
            #1;
            check("arb_resp_ready", resp_ready, 1'b1);
            tick();
            resp_valid = 1'b0;
            rsp_ready  = exp_gnt;
            #1;
            check("arb_rsp_valid", rsp_valid, exp_gnt);
            check("arb_rsp_data", rsp_data, id_resp);
            tick();
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;

        // Back-pressure: requester 1 INTERVAL 5, controller stalls 3 cycles
        req_valid   = 2'b10;
        req_data[1] = mk(CONTROL_INTERVAL, 28'd5);
        #1;
        check("bp_grant1", req_ready, 2'b10);
        tick();
        req_valid   = 2'b01;
        req_data[0] = mk(CONTROL_ACTIVE, 28'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_stall_valid", ctrl_valid, 1'b1);
            check("bp_stall_data", ctrl_data, mk(CONTROL_INTERVAL, 28'd5));
            check("bp_no_grant", req_ready, 2'b00);
            tick();
        end
        ctrl_ready = 1'b1;
        #1;
        check("bp_hs_valid", ctrl_valid, 1'b1);
        check("bp_hs_data", ctrl_data, mk(CONTROL_INTERVAL, 28'd5));
        tick();
        ctrl_ready = 1'b0;
        #1;
        check("bp_next_grant0", req_ready, 2'b01);
        check("bp_ctrl_idle", ctrl_valid, 1'b0);
        tick();
        req_valid  = 2'b00;
        ctrl_ready = 1'b1;
        #1;
        check("bp_active_data", ctrl_data, mk(CONTROL_ACTIVE, 28'd1));
        tick();
        ctrl_ready = 1'b0;

        // Response steering: requester 1 PARAM ROWS, slow to accept
        req_valid   = 2'b11;
        req_data[0] = mk(CONTROL_ID, 28'd0);
        req_data[1] = mk(CONTROL_PARAM, 28'(CONTROL_PARAM_ROWS));
        #1;
        check("st_grant1", req_ready, 2'b10);
        tick();
        req_valid  = 2'b01;
        ctrl_ready = 1'b1;
        #1;
        check("st_ctrl_data", ctrl_data, mk(CONTROL_PARAM, 28'(CONTROL_PARAM_ROWS)));
        tick();
        ctrl_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'd3;
        tick();
        resp_valid = 1'b0;
        rsp_ready  = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("st_hold_valid", rsp_valid, 2'b10);
            check("st_hold_data", rsp_data, 32'd3);
            check("st_no_grant", req_ready, 2'b00);
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        check("st_hs_valid", rsp_valid, 2'b10);
        tick();
        rsp_ready = 2'b00;
        #1;
        check("st_rsp_clear", rsp_valid, 2'b00);
        check("st_grant0", req_ready, 2'b01);
        tick();
        req_valid  = 2'b00;
        ctrl_ready = 1'b1;
        #1;
        check("st_id_data", ctrl_data, mk(CONTROL_ID, 28'd0));
        tick();
        ctrl_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data  = id_resp;
        tick();
        resp_valid = 1'b0;
        rsp_ready  = 2'b01;
        #1;
        check("st_id_rsp_valid", rsp_valid, 2'b01);
        tick();
        rsp_ready = 2'b00;

        // Watchdog expiry: STATUS from requester 1, controller silent
        req_valid   = 2'b10;
        req_data[1] = mk(CONTROL_STATUS, 28'd0);
        #1;
        check("wd_grant1", req_ready, 2'b10);
        tick();
        req_valid  = 2'b00;
        ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("wd_quiet", timeout, 1'b0);
            tick();
        end
        #1;
        check("wd_pulse", timeout, 1'b1);
        check("wd_no_rsp", rsp_valid, 2'b00);
        tick();
        resp_valid = 1'b1;
        resp_data  = id_resp;
        #1;
        check("wd_pulse_end", timeout, 1'b0);
        check("wd_stray_ready", resp_ready, 1'b1);
        tick();
        resp_valid = 1'b0;
        #1;
        check("wd_stray_dropped", rsp_valid, 2'b00);
        check("wd_ctrl_idle", ctrl_valid, 1'b0);

        // Watchdog collision: response in the expiry cycle
        req_valid   = 2'b01;
        req_data[0] = mk(CONTROL_CYCLES, 28'd0);
        #1;
        check("col_grant0", req_ready, 2'b01);
        tick();
        req_valid  = 2'b00;
        ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        repeat (7) tick();
        resp_valid = 1'b1;
        resp_data  = 32'h0000_1234;
        tick();
        resp_valid = 1'b0;
        rsp_ready  = 2'b01;
        #1;
        check("col_no_timeout", timeout, 1'b0);
        check("col_rsp_valid", rsp_valid, 2'b01);
        check("col_rsp_data", rsp_data, 32'h0000_1234);
        tick();
        rsp_ready = 2'b00;
        #1;
        check("col_no_timeout_late", timeout, 1'b0);
        check("col_rsp_clear", rsp_valid, 2'b00);

        // Reset while in RETURN
        req_valid   = 2'b01;
        req_data[0] = mk(CONTROL_VERSION, 28'd0);
        #1;
        check("mr_grant0", req_ready, 2'b01);
        tick();
        req_valid  = 2'b00;
        ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'h0000_ABCD;
        tick();
        resp_valid = 1'b0;
        #1;
        check("mr_in_return", rsp_valid, 2'b01);
        rst = 1'b0;
        #1;
        check("mr_req_ready", req_ready, 2'b00);
        check("mr_ctrl_valid", ctrl_valid, 1'b0);
        check("mr_ctrl_data", ctrl_data, 32'd0);
        check("mr_resp_ready", resp_ready, 1'b1);
        check("mr_rsp_valid", rsp_valid, 2'b00);
        check("mr_rsp_data", rsp_data, 32'd0);
        check("mr_timeout", timeout, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b1;
        req_valid   = 2'b11;
        req_data[0] = mk(CONTROL_ID, 28'd0);
        req_data[1] = mk(CONTROL_ID, 28'd0);
        #1;
        check("mr_priority0", req_ready, 2'b01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nx_control_arbiter.md
# nx_control_arbiter

Round-robin arbiter that shares the single control message stream of the Nexus top-level controller between `REQUESTERS` independent command sources, such as the host link and an on-chip debug port. It forwards one command at a time into the controller. When the command produces a response, it holds the grant until that response has been routed back to the requester that issued it. A configurable watchdog frees the arbiter if the controller never answers.

## Interface

- `REQUESTERS`, default 2: number of command sources (2..8).
- `TIMEOUT`, default 1024: cycles to wait for a response before abandoning it; 0 disables the watchdog.

- `i_clk` input 1: clock.
- `i_rst` input 1: reset; **asynchronous, active-low**.
- `i_req_data` input `REQUESTERS`×`control_message_t`: per-requester command.
- `i_req_valid` input `REQUESTERS`: command valid.
- `o_req_ready` output `REQUESTERS`: command accepted (one-hot or zero).
- `o_ctrl_data` output `control_message_t`: command to the controller.
- `o_ctrl_valid` output 1: command valid.
- `i_ctrl_ready` input 1: controller accepts the command.
- `i_resp_data` input `control_response_t`: response from the controller.
- `i_resp_valid` input 1: response valid.
- `o_resp_ready` output 1: response accepted.
- `o_rsp_data` output `control_response_t`: response, broadcast to all requesters.
- `o_rsp_valid` output `REQUESTERS`: one-hot response valid, owner only.
- `i_rsp_ready` input `REQUESTERS`: requester accepts its response.
- `o_timeout` output 1: single-cycle pulse when the watchdog expires.

## Operation

- **FSM states:**
  - IDLE: no grant held.
  - FORWARD: registered command driving `o_ctrl_valid`.
  - WAIT: awaiting the response.
  - RETURN: registered response driving `o_rsp_valid`.
- **IDLE:**
  - If any `i_req_valid` is set, pick the winner by round-robin.
  - Raise `o_req_ready[winner]` combinationally.
  - Capture the data and owner index, then go to FORWARD.
- **Round-robin:**
  - Search starts at `last_grant+1` and wraps modulo `REQUESTERS`.
  - `last_grant` resets to `REQUESTERS-1`, so requester 0 wins first.
  - `last_grant` updates only on acceptance.
- **FORWARD:**
  - `o_ctrl_valid`=1 and the data is held stable until `i_ctrl_ready`.
  - On handshake, go to WAIT if the command expects a response, otherwise to IDLE.
  - Commands that expect a response: ID, VERSION, PARAM, STATUS, CYCLES.
  - Commands that do not: ACTIVE, INTERVAL, RESET, and unknown opcodes.
- **WAIT:**
  - `o_resp_ready`=1.
  - On `i_resp_valid`, capture the response and go to RETURN.
  - Watchdog counter increments each WAIT cycle.
  - When the count reaches `TIMEOUT`, pulse `o_timeout` and go to IDLE without a response.
- **RETURN:**
  - Assert `o_rsp_valid[owner]` only.
  - Hold the data until `i_rsp_ready[owner]`, then go to IDLE.
  - `i_rsp_ready` of non-owners is ignored.
- **Stray responses:** in IDLE, `o_resp_ready`=1 and any `i_resp_valid` is accepted and discarded. This covers a late response to a timed-out command. In FORWARD and RETURN, `o_resp_ready`=0.
- **Watchdog width:** `$clog2(TIMEOUT+1)` bits; cleared on entry to WAIT; never wraps.
- **Reset mid-operation:** asynchronous return to IDLE. All held commands and responses are dropped and the round-robin pointer is restored.

## Timing

- **Reset values:** `o_req_ready`=0, `o_ctrl_valid`=0, `o_ctrl_data`=0, `o_resp_ready`=1, `o_rsp_valid`=0, `o_rsp_data`=0, `o_timeout`=0.
- **Command latency:** accept in cycle N gives `o_ctrl_valid` in N+1.
- **Response latency:** `i_resp_valid` accepted in cycle M gives `o_rsp_valid` in M+1.
- **No bypass:** every payload passes through a register.
- **Back-to-back grants:**
  - A no-response command handshaken in cycle K allows the next `o_req_ready` in K+1.
  - After the RETURN handshake in cycle K, the next grant is in K+1.
- **Registered outputs:** `o_ctrl_*`, `o_rsp_*` and `o_timeout` are registered.
- **Combinational outputs:** `o_req_ready` and `o_resp_ready` decode state combinationally; `o_req_ready` also depends on `i_req_valid`.
- **Requester rule:** once valid is raised it must be held, with stable data, until ready.
- **Watchdog timing:** with `TIMEOUT`=T and no response, `o_timeout` pulses T cycles after WAIT entry. The FSM is in IDLE the following cycle.
- **Simultaneous events:**
  - If the response arrives in the same cycle the watchdog expires, the response wins. It goes to RETURN and `o_timeout` is not pulsed.
  - If all requesters are valid together, grants rotate one per transaction.

## Structure

- **Shared package:** `NXConstants` gains the function `control_command_expects_response(control_command_t)`. It returns 1 for ID, VERSION, PARAM, STATUS and CYCLES.
- **Reused types:** `control_message_t` and `control_response_t` are used unchanged.
- **Sub-module:** `nx_rr_arbiter`, a parameterised round-robin arbiter.
  - Inputs: request vector and enable.
  - Outputs: one-hot grant and grant index.
  - Holds the `last_grant` register; reusable elsewhere in the mesh.
- **Top level:** contains the FSM, the command and response holding registers, the owner register and the watchdog.

## Test plan

- **Arbitration order:** after reset, requesters 0 and 1 both issue ID continuously. Expected: grants 0,1,0,1. Each owner receives `o_rsp_data`=HW_DEV_ID[23:0] only on its own `o_rsp_valid` bit.
- **Back-pressure and rotation:** requester 1 sends INTERVAL payload 5 while `i_ctrl_ready` is held low for 3 cycles. Expected: `o_ctrl_valid` and data stable for 4 cycles, no WAIT entry, requester 0 granted the cycle after the handshake.
- **Response steering:** requester 1 sends PARAM ROWS with `i_rsp_ready[1]`=0 for 5 cycles, returning 3. Expected: `o_rsp_valid`=2'b10 held, data=3, no new grant to requester 0 until the handshake.
- **Watchdog expiry:** `TIMEOUT`=8, STATUS sent and controller silent. Expected:
  - `o_timeout` pulses once, 8 cycles after WAIT entry.
  - A response injected afterwards is accepted and discarded, with no `o_rsp_valid`.
- **Watchdog collision:** response arrives in the exact expiry cycle. Expected: the response is delivered and there is no `o_timeout`.
- **Reset mid-operation:** `i_rst` is asserted low while in RETURN. Expected:
  - All outputs return to their reset values immediately.
  - After release, requester 0 has priority again.
